dut_fsm_checker_mc: RTL and testbench
=====================================

# dut_fsm_checker_mc

Multi-channel, parametrised checker for DUT state-machine outputs in SEU/TMR test setups. Each channel watches one DUT output bus and checks two things:
- every expected code appears at least once per observation window;
- the illegal (all-ones) code never appears.

The block also flags disagreement between channels and keeps per-channel sticky flags and saturating error counters for readout. It sits between the DUT I/O capture and the slow-control register bank.

## Interface
Parameters:
- N_CH, 3: number of monitored channels (3 = one TMR triplet); ≥1.
- IO_SIZE_G, 4: width of each channel's data bus; ≥2.
- N_CODES, 3: codes 1..N_CODES must each be seen once per window; 1 ≤ N_CODES ≤ 2^IO_SIZE_G−2.
- WIN_W, 4: window length is 2^WIN_W enabled cycles; ≥2.
- CNT_W, 16: width of each per-channel error counter.

Ports:
- clk_i, in, 1: single clock.
- rst_n_i, in, 1: reset, asynchronous and active-low.
- en_i, in, 1: checking enable; 0 freezes the window counter and markers and suppresses all error generation.
- clr_i, in, 1: synchronous clear of window counter, markers, sticky flags and counters; has priority over en_i.
- data_i, in, N_CH*IO_SIZE_G: channel c occupies bits [c*IO_SIZE_G +: IO_SIZE_G].
- err_data_o, out, N_CH: 1-cycle pulse; channel missed ≥1 expected code in the window just closed.
- err_state_o, out, N_CH: 1-cycle pulse per cycle in which the channel showed the illegal code.
- err_vote_o, out, 1: channels disagreed in the previous cycle; always 0 when N_CH=1.
- err_sticky_o, out, N_CH: set on any data or state error of that channel; cleared only by clr_i or reset.
- err_cnt_o, out, N_CH*CNT_W: per-channel error-event counters, saturating.

## Operation
- Reset (rst_n_i=0): every register and every output is 0.
- Window counter: one WIN_W-bit counter shared by all channels.
  - Increments on each cycle with en_i=1 and clr_i=0.
  - `win_end` is asserted on the cycle where the counter equals 2^WIN_W−1; the counter then wraps to 0.
- Markers: each channel has an N_CODES-bit marker register.
  - On a non-`win_end` enabled cycle, a channel value k with 1 ≤ k ≤ N_CODES sets marker bit k−1.
  - Value 0, values above N_CODES and the illegal code leave the markers unchanged.
- Window close (`win_end` cycle):
  - err_data_o[c] becomes 1 if channel c's markers are not all-ones.
  - All markers clear to 0.
  - data_i on the `win_end` cycle is not recorded.
- Illegal code: data equal to 2^IO_SIZE_G−1 on an enabled cycle makes err_state_o[c]=1. This is checked on every enabled cycle, including `win_end`.
- Vote: err_vote_o=1 if any channel's data differs from channel 0 on an enabled cycle.
- Error event for channel c: a data error or a state error in the same cycle.
  - Sets err_sticky_o[c].
  - Increments err_cnt_o[c] by exactly 1, even when both errors occur together.
  - The counter holds at 2^CNT_W−1 and does not wrap.
- en_i=0: pulse outputs are 0 the following cycle. Markers, counter, sticky flags and counters hold.
- clr_i=1: window counter, markers, sticky flags and counters go to 0, and pulse outputs are 0 the following cycle. No error from the clr_i cycle is counted.

## Timing
- All outputs are registered. A condition on data_i at cycle t appears on err_state_o, err_vote_o, err_sticky_o and err_cnt_o at t+1.
- err_data_o goes high in the cycle after `win_end`. The first `win_end` after reset or clear is the 2^WIN_W-th enabled cycle.
- Counter and sticky update in the same cycle as the corresponding pulse.
- If reset is asserted mid-window, outputs clear immediately (asynchronously). The next window starts from 0.

## Structure
- Shared package/header holds:
  - the illegal-code constant (all-ones of IO_SIZE_G);
  - the clog2 helper;
  - the channel-slice macro/function.
- Sub-module `dut_fsm_chk_ch` is instantiated N_CH times. It contains markers, the illegal-code compare, sticky flag and saturating counter, and takes `win_end`, en and clr as inputs.
- The top level holds the window counter and the vote comparator.

## Test plan
- Defaults; each channel cycles 1,2,3,0 continuously for 2 windows → err_data_o stays 0, err_cnt_o=0, err_vote_o=0.
- Channel 1 never shows 3 in the first window → err_data_o=3'b010 for exactly one cycle, at cycle 17 after reset release; err_cnt_o[1]=1; sticky[1]=1.
- Channel 2 shows 15 for 3 consecutive cycles → err_state_o[2] high 3 cycles (each one cycle later), err_vote_o high 3 cycles, err_cnt_o[2]=3.
- Code 2 presented only on the `win_end` cycle (and nowhere else in the window) → err_data_o fires for all channels.
- Data error and state error in the same cycle with CNT_W=2, repeated 5 times → counter increments by 1 per event and saturates at 3.
- en_i=0 for 10 cycles mid-window, then clr_i=1 → window extended by 10 cycles during disable; after clear, sticky=0, counters=0, next `win_end` 16 enabled cycles later.

Source files
------------

// File: rtl/dut_fsm_checker_mc_pkg.sv
// Shared definitions for the multi-channel DUT FSM output checker.
// Provides the illegal-code constant, a clog2 helper and the channel-slice offset helper.
package dut_fsm_checker_mc_pkg;

  // Ceiling log2 for sizing counters; returns 0 for v <= 1.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // All-ones code of width w: the illegal FSM encoding.
  function automatic int unsigned illegal_code(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // LSB position of channel c on a flat bus of w-bit channels.
  function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/dut_fsm_chk_ch.sv
// Single-channel checker: code markers, illegal-code compare, sticky flag and
// saturating error-event counter.
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   en_i, clr_i        checking enable, synchronous clear (clr_i wins)
//   win_end_i          last enabled cycle of the observation window
//   data_i             this channel's DUT output bus
//   err_data_o         pulse: an expected code was missing in the closed window
//   err_state_o        pulse: illegal code seen
//   err_sticky_o       sticky OR of all error events
//   err_cnt_o          saturating error-event count
module dut_fsm_chk_ch
  import dut_fsm_checker_mc_pkg::*;
#(
  parameter int unsigned IO_SIZE_G = 4,
  parameter int unsigned N_CODES   = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 win_end_i,
  input  logic [IO_SIZE_G-1:0] data_i,
  output logic                 err_data_o,
  output logic                 err_state_o,
  output logic                 err_sticky_o,
  output logic [CNT_W-1:0]     err_cnt_o
);

  localparam logic [IO_SIZE_G-1:0] Illegal = IO_SIZE_G'(illegal_code(IO_SIZE_G));

  logic [N_CODES-1:0] marker_q, marker_d;
  logic               err_data_q, err_data_d;
  logic               err_state_q, err_state_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active;
  logic               evt;

  always_comb begin
    active   = en_i & ~clr_i;
    marker_d = marker_q;
    if (clr_i) begin
      marker_d = '0;
    end else if (active) begin
      if (win_end_i) begin
        // The window-close sample is deliberately not recorded.
        marker_d = '0;
      end else begin
        for (int k = 0; k < int'(N_CODES); k++) begin
          if (data_i == IO_SIZE_G'(k + 1)) marker_d[k] = 1'b1;
        end
      end
    end

    err_data_d  = active & win_end_i & ~(&marker_q);
    err_state_d = active & (data_i == Illegal);
    // Simultaneous data and state errors form a single event.
    evt         = err_data_d | err_state_d;

    sticky_d = clr_i ? 1'b0 : (sticky_q | evt);

    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (evt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      marker_q    <= '0;
      err_data_q  <= 1'b0;
      err_state_q <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      marker_q    <= marker_d;
      err_data_q  <= err_data_d;
      err_state_q <= err_state_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign err_data_o   = err_data_q;
  assign err_state_o  = err_state_q;
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: rtl/dut_fsm_checker_mc.sv
// Multi-channel checker for DUT state-machine outputs (SEU/TMR setups).
// Holds the shared window counter and the inter-channel vote comparator;
// per-channel checks live in dut_fsm_chk_ch.
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   en_i, clr_i        checking enable, synchronous clear (clr_i wins)
//   data_i             N_CH packed channel buses, channel c at [c*IO_SIZE_G +: IO_SIZE_G]
//   err_data_o         per-channel missing-code pulse after each window
//   err_state_o        per-channel illegal-code pulse
//   err_vote_o         channels disagreed in the previous enabled cycle
//   err_sticky_o       per-channel sticky error flags
//   err_cnt_o          per-channel saturating error counters, CNT_W each
module dut_fsm_checker_mc
  import dut_fsm_checker_mc_pkg::*;
#(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned IO_SIZE_G = 4,
  parameter int unsigned N_CODES   = 3,
  parameter int unsigned WIN_W     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [N_CH*IO_SIZE_G-1:0] data_i,
  output logic [N_CH-1:0]           err_data_o,
  output logic [N_CH-1:0]           err_state_o,
  output logic                      err_vote_o,
  output logic [N_CH-1:0]           err_sticky_o,
  output logic [N_CH*CNT_W-1:0]     err_cnt_o
);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_end;
  logic             vote_q, vote_d;

  always_comb begin
    win_end   = (win_cnt_q == {WIN_W{1'b1}});
    win_cnt_d = win_cnt_q;
    if (clr_i) begin
      win_cnt_d = '0;
    end else if (en_i) begin
      // Natural wrap to 0 right after win_end.
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end

    vote_d = 1'b0;
    if (en_i && !clr_i) begin
      for (int c = 1; c < int'(N_CH); c++) begin
        if (data_i[c*IO_SIZE_G +: IO_SIZE_G] != data_i[0 +: IO_SIZE_G]) vote_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt_q <= '0;
      vote_q    <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      vote_q    <= vote_d;
    end
  end

  assign err_vote_o = vote_q;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    dut_fsm_chk_ch #(
      .IO_SIZE_G (IO_SIZE_G),
      .N_CODES   (N_CODES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .en_i         (en_i),
      .clr_i        (clr_i),
      .win_end_i    (win_end),
      .data_i       (data_i[ch_lsb(c, IO_SIZE_G) +: IO_SIZE_G]),
      .err_data_o   (err_data_o[c]),
      .err_state_o  (err_state_o[c]),
      .err_sticky_o (err_sticky_o[c]),
      .err_cnt_o    (err_cnt_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_dut_fsm_checker_mc.sv
// Scoreboard bench for dut_fsm_checker_mc: stimulus pushes expected outputs
// from a behavioural model; a monitor pops and compares one entry per cycle.
module tb_dut_fsm_checker_mc;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned IO      = 4;
  localparam int unsigned N_CODES = 3;
  localparam int unsigned WIN_W   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned WinLen  = 2 ** WIN_W;
  localparam int unsigned CntMax  = 2 ** CNT_W - 1;
  localparam int unsigned IllVal  = 2 ** IO - 1;

  logic                  clk_i = 1'b0;
  logic                  rst_n_i;
  logic                  en_i;
  logic                  clr_i;
  logic [N_CH*IO-1:0]    data_i;
  logic [N_CH-1:0]       err_data_o;
  logic [N_CH-1:0]       err_state_o;
  logic                  err_vote_o;
  logic [N_CH-1:0]       err_sticky_o;
  logic [N_CH*CNT_W-1:0] err_cnt_o;

  dut_fsm_checker_mc #(
    .N_CH      (N_CH),
    .IO_SIZE_G (IO),
    .N_CODES   (N_CODES),
    .WIN_W     (WIN_W),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .data_i       (data_i),
    .err_data_o   (err_data_o),
    .err_state_o  (err_state_o),
    .err_vote_o   (err_vote_o),
    .err_sticky_o (err_sticky_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N_CH-1:0]       dat;
    logic [N_CH-1:0]       st;
    logic                  vote;
    logic [N_CH-1:0]       sticky;
    logic [N_CH*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state: enabled-cycle position in window, set of codes seen,
  // raw (unsaturated) error-event tally and sticky flags.
  int unsigned pos;
  bit          seen[N_CH][N_CODES];
  int unsigned errs[N_CH];
  bit          sticky_m[N_CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int c = 0; c < int'(N_CH); c++) begin
      errs[c] = 0;
      sticky_m[c] = 0;
      for (int k = 0; k < int'(N_CODES); k++) seen[c][k] = 0;
    end
  endtask

  task automatic model_step(input logic en, input logic clr, input logic [N_CH*IO-1:0] d);
    exp_t e;
    e = '0;
    if (clr) begin
      model_reset();
    end else if (en) begin
      bit last;
      int unsigned v0;
      last = (pos == WinLen - 1);
      v0 = int'(d[0 +: IO]);
      for (int c = 0; c < int'(N_CH); c++) begin
        int unsigned v;
        int unsigned n;
        bit derr, serr;
        v = int'(d[c*IO +: IO]);
        serr = (v == IllVal);
        derr = 0;
        if (last) begin
          n = 0;
          for (int k = 0; k < int'(N_CODES); k++) if (seen[c][k]) n++;
          derr = (n != N_CODES);
          for (int k = 0; k < int'(N_CODES); k++) seen[c][k] = 0;
        end else if (v >= 1 && v <= N_CODES) begin
          seen[c][v-1] = 1;
        end
        if (derr || serr) begin
          errs[c]++;
          sticky_m[c] = 1;
        end
        e.dat[c] = derr;
        e.st[c]  = serr;
        if (v != v0) e.vote = 1'b1;
      end
      pos = (pos + 1) % WinLen;
    end
    for (int c = 0; c < int'(N_CH); c++) begin
      e.sticky[c] = sticky_m[c];
      e.cnt[c*CNT_W +: CNT_W] = CNT_W'((errs[c] > CntMax) ? CntMax : errs[c]);
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic en, input logic clr, input logic [N_CH*IO-1:0] d);
    @(negedge clk_i);
    en_i   = en;
    clr_i  = clr;
    data_i = d;
    model_step(en, clr, d);
  endtask

  // Monitor: one registered response per cycle, sampled away from the edge.
  always @(posedge clk_i) begin
    #2;
    if (rst_n_i && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("err_data",   64'(err_data_o),   64'(e.dat));
      check("err_state",  64'(err_state_o),  64'(e.st));
      check("err_vote",   64'(err_vote_o),   64'(e.vote));
      check("err_sticky", 64'(err_sticky_o), 64'(e.sticky));
      check("err_cnt",    64'(err_cnt_o),    64'(e.cnt));
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk_i);
      #3;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},   64'(err_data_o),   64'd0);
    check({tag, "_state"},  64'(err_state_o),  64'd0);
    check({tag, "_vote"},   64'(err_vote_o),   64'd0);
    check({tag, "_sticky"}, 64'(err_sticky_o), 64'd0);
    check({tag, "_cnt"},    64'(err_cnt_o),    64'd0);
  endtask

  // Mid-run asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    drain();
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    clr_i   = 1'b0;
    data_i  = '0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  function automatic logic [IO-1:0] pat(input int i);
    return (i % 4 == 3) ? IO'(0) : IO'(i % 4 + 1);
  endfunction

  initial begin
    logic [IO-1:0]      v;
    logic [N_CH*IO-1:0] d;
    rst_n_i = 1'b0;
    en_i    = 1'b0;
    clr_i   = 1'b0;
    data_i  = '0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Clean 1,2,3,0 cycling for two windows on all channels.
    for (int i = 0; i < 2 * int'(WinLen); i++) begin
      v = pat(i);
      drive(1'b1, 1'b0, {N_CH{v}});
    end

    // Channel 1 never shows 3 in the first window after reset.
    do_reset();
    for (int i = 0; i < int'(WinLen) + 4; i++) begin
      v = pat(i);
      d = {N_CH{v}};
      if (v == IO'(3)) d[1*IO +: IO] = '0;
      drive(1'b1, 1'b0, d);
    end

    // Channel 2 shows the illegal code for three consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      v = pat(i);
      d = {N_CH{v}};
      if (i >= 2 && i < 5) d[2*IO +: IO] = IO'(IllVal);
      drive(1'b1, 1'b0, d);
    end

    // Code 2 only on the window-close cycle: every channel reports missing codes.
    do_reset();
    for (int i = 0; i < int'(WinLen) + 2; i++) begin
      v = (pos == WinLen - 1) ? IO'(2) : IO'(0);
      drive(1'b1, 1'b0, {N_CH{v}});
    end

    // Data and state error together on each window close, until saturation.
    do_reset();
    for (int i = 0; i < 9 * int'(WinLen) + 2; i++) begin
      v = (pos == WinLen - 1) ? IO'(IllVal) : IO'(0);
      drive(1'b1, 1'b0, {N_CH{v}});
    end

    // Disable for 10 cycles mid-window, then clear and run a fresh window.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, {N_CH{pat(i)}});
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, {N_CH{IO'(IllVal)}});
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, {N_CH{pat(i)}});
    drive(1'b1, 1'b1, {N_CH{IO'(IllVal)}});
    for (int i = 0; i < int'(WinLen) + 3; i++) begin
      v = (i == 4) ? IO'(0) : pat(i);
      drive(1'b1, 1'b0, {N_CH{v}});
    end

    // Randomised traffic with occasional disable and clear.
    for (int i = 0; i < 2000; i++) begin
      logic en, clr;
      en  = ($urandom % 8) != 0;
      clr = ($urandom % 48) == 0;
      v   = IO'($urandom_range(0, 4));
      if ($urandom % 20 == 0) v = IO'(IllVal);
      for (int c = 0; c < int'(N_CH); c++) begin
        d[c*IO +: IO] = ($urandom % 10 == 0) ? IO'($urandom) : v;
      end
      drive(en, clr, d);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
